uart_num2ascii_stream: RTL and testbench

Sequential successor to the single-digit number-to-ASCII lookup. Accepts a WIDTH-bit unsigned value through a valid/ready handshake and converts it to decimal (iterative double-dabble) or hexadecimal. Streams the result one ASCII byte per handshake, most-significant digit first, with leading-zero suppression and an optional CR/LF terminator. Sits between the application and the buffered UART TX FIFO (out_* connects to the FIFO write side).

---
 rtl/uart_ascii_pkg.sv | 23 ++
 rtl/uart_bin2bcd.sv | 55 +++++
 rtl/uart_num2ascii_stream.sv | 154 +++++++++++++++
 tb/tb_uart_num2ascii_stream.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_ascii_pkg.sv
// Shared constants, FSM states and helpers for the number-to-ASCII streamer.
// ASCII code points, the emitter state enum and the hex digit count helper.
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_A     = 8'd65;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;
  localparam logic [7:0] ASCII_QMARK = 8'd63;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT,
    TERM_CR,
    TERM_LF
  } state_t;

  function automatic int hex_digits(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/uart_bin2bcd.sv
// Iterative double-dabble binary to BCD converter, one bit per cycle.
// start loads bin; done is high during the final (WIDTH-th) shift cycle.
module uart_bin2bcd
  import uart_ascii_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEC_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic [DEC_DIGITS*4-1:0] bcd,
  output logic                    done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]        sh;
  logic [CW-1:0]           cnt;
  logic                    run;
  logic [DEC_DIGITS*4-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      bcd <= {adj[DEC_DIGITS*4-2:0], sh[WIDTH-1]};
      sh  <= {sh[WIDTH-2:0], 1'b0};
      cnt <= cnt + CW'(1);
      if (done)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_num2ascii_stream.sv
// Converts a binary value to decimal/hex ASCII, streamed MSD first.
// Ports: in_* value handshake, out_* byte handshake to TX FIFO, busy.
module uart_num2ascii_stream
  import uart_ascii_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEC_DIGITS  = 5,
  parameter int APPEND_CRLF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic             in_hex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  localparam int HD = hex_digits(WIDTH);
  localparam int ND = (DEC_DIGITS > HD) ? DEC_DIGITS : HD;
  localparam int PW = $clog2(ND);
  localparam logic [PW-1:0] PZ = '0;

  state_t state, nxt;

  logic [WIDTH-1:0]        num_q;
  logic                    hex_q;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           lead;
  logic [PW-1:0]           cur;
  logic                    fresh;
  logic [DEC_DIGITS*4-1:0] bcd;
  logic                    bcd_done;
  logic [ND*4-1:0]         digs;
  logic [3:0]              dig;
  logic                    accept;
  logic                    last_dig;

  function automatic logic [7:0] to_ascii(
    input logic [3:0] d,
    input logic       hx
  );
    logic [7:0] c;
    c = ASCII_QMARK;
    unique case (1'b1)
      (d < 4'd10):         c = ASCII_ZERO + {4'd0, d};
      (d >= 4'd10) && hx:  c = ASCII_A + {4'd0, d - 4'd10};
      (d >= 4'd10) && !hx: c = ASCII_QMARK;
      default:             c = ASCII_QMARK;
    endcase
    return c;
  endfunction

  assign accept = in_valid && (state == IDLE);

  uart_bin2bcd #(
    .WIDTH      (WIDTH),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !in_hex),
    .bin   (in_num),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  assign digs = hex_q ? (ND*4)'(num_q) : (ND*4)'(bcd);

  // Highest nonzero digit; all-zero falls to digit 0 so "0" is emitted.
  always_comb begin
    lead = '0;
    for (int i = 1; i < ND; i++) begin
      if (digs[i*4 +: 4] != 4'd0)
        lead = PW'(i);
    end
  end

  // fresh marks the first EMIT byte: pointer comes straight from the
  // encoder, so suppression adds no cycle.
  assign cur      = fresh ? lead : ptr;
  assign dig      = digs[cur*4 +: 4];
  assign last_dig = (cur == PZ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (in_valid)
          nxt = in_hex ? EMIT : CONVERT;
      CONVERT:
        if (bcd_done)
          nxt = EMIT;
      EMIT:
        if (out_ready && last_dig)
          nxt = (APPEND_CRLF != 0) ? TERM_CR : IDLE;
      TERM_CR:
        if (out_ready)
          nxt = TERM_LF;
      TERM_LF:
        if (out_ready)
          nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'd0;
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    unique case (state)
      EMIT: begin
        out_valid = 1'b1;
        out_data  = to_ascii(dig, hex_q);
      end
      TERM_CR: begin
        out_valid = 1'b1;
        out_data  = ASCII_CR;
      end
      TERM_LF: begin
        out_valid = 1'b1;
        out_data  = ASCII_LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q <= '0;
      hex_q <= 1'b0;
      ptr   <= '0;
      fresh <= 1'b0;
    end else if (accept) begin
      num_q <= in_num;
      hex_q <= in_hex;
      fresh <= 1'b1;
    end else if (state == EMIT && out_ready) begin
      fresh <= 1'b0;
      ptr   <= cur - PW'(1);
    end
  end

endmodule

// File: tb/tb_uart_num2ascii_stream.sv
// Directed bench for uart_num2ascii_stream (16-bit CRLF and 32-bit bare).
// Expected bytes come from a queue filled by a reference formatter.
module tb_uart_num2ascii_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_iv = 0, a_ir, a_hex = 0, a_ov, a_or = 1, a_busy;
  logic [15:0] a_num = '0;
  logic [7:0]  a_od;
  logic        b_iv = 0, b_ir, b_hex = 0, b_ov, b_or = 1, b_busy;
  logic [31:0] b_num = '0;
  logic [7:0]  b_od;

  int checks = 0;
  int errors = 0;

  uart_num2ascii_stream #(
    .WIDTH(16), .DEC_DIGITS(5), .APPEND_CRLF(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_num(a_num), .in_hex(a_hex),
    .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .busy(a_busy)
  );

  uart_num2ascii_stream #(
    .WIDTH(32), .DEC_DIGITS(10), .APPEND_CRLF(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_num(b_num), .in_hex(b_hex),
    .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .busy(b_busy)
  );

  task automatic chk(input string tag, input longint got,
                     input longint want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic ov(input bit s);
    return s ? b_ov : a_ov;
  endfunction
  function automatic logic ir(input bit s);
    return s ? b_ir : a_ir;
  endfunction
  function automatic logic bz(input bit s);
    return s ? b_busy : a_busy;
  endfunction
  function automatic logic [7:0] od(input bit s);
    return s ? b_od : a_od;
  endfunction

  byte unsigned sb[$];

  task automatic push_expected(input longint unsigned n, input bit hex,
                               input bit crlf);
    byte unsigned tmp[$];
    longint unsigned v, d, base;
    v = n;
    base = hex ? 16 : 10;
    do begin
      d = v % base;
      tmp.push_front(byte'(d < 10 ? 48 + d : 55 + d));
      v = v / base;
    end while (v != 0);
    foreach (tmp[i]) sb.push_back(tmp[i]);
    if (crlf) begin
      sb.push_back(8'd13);
      sb.push_back(8'd10);
    end
  endtask

  task automatic xfer(input bit s, input logic [31:0] num, input bit hex,
                      input bit stall, input int exp_lat, input bit crlf);
    int lat, k;
    bit hold, rdy;
    logic [7:0] held;
    byte unsigned e;
    push_expected(num, hex, crlf);
    @(negedge clk);
    chk("in_ready_idle", ir(s), 1);
    if (s) begin
      b_num = num; b_hex = hex; b_iv = 1;
    end else begin
      a_num = num[15:0]; a_hex = hex; a_iv = 1;
    end
    @(negedge clk);
    a_iv = 0; b_iv = 0;
    chk("busy_after_accept", bz(s), 1);
    chk("in_ready_after_accept", ir(s), 0);
    lat = 1;
    while (!ov(s) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, exp_lat);
    k = 0;
    hold = 0;
    held = '0;
    while (sb.size() > 0 && k < 400) begin
      rdy = stall ? (k % 3 == 0) : 1'b1;
      a_or = rdy; b_or = rdy;
      chk("valid_while_emitting", ov(s), 1);
      if (hold) chk("stall_stable", od(s), held);
      if (rdy && ov(s)) begin
        e = sb.pop_front();
        chk("byte", od(s), e);
        hold = 0;
      end else begin
        hold = ov(s);
        held = od(s);
      end
      k++;
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      chk("emit_timeout", sb.size(), 0);
      sb.delete();
    end
    a_or = 1; b_or = 1;
    chk("valid_after_last", ov(s), 0);
    chk("in_ready_after_last", ir(s), 1);
    chk("busy_after_last", bz(s), 0);
  endtask

  initial begin
    int g;
    #2;
    chk("rst_out_valid", a_ov, 0);
    chk("rst_in_ready", a_ir, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_data", a_od, 0);
    @(negedge clk);
    rst = 0;

    xfer(0, 32'd1234, 0, 0, 17, 1);
    xfer(0, 32'd0, 0, 0, 17, 1);
    xfer(0, 32'd65535, 0, 0, 17, 1);
    xfer(0, 32'd9, 0, 0, 17, 1);
    xfer(0, 32'hBEEF, 1, 0, 1, 1);
    xfer(0, 32'h00A5, 1, 0, 1, 1);
    xfer(0, 32'd42, 0, 1, 17, 1);

    @(negedge clk);
    a_num = 16'd1234; a_hex = 0; a_iv = 1;
    @(negedge clk);
    a_iv = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_conv_out_valid", a_ov, 0);
    chk("rst_conv_in_ready", a_ir, 1);
    chk("rst_conv_busy", a_busy, 0);
    @(negedge clk);
    rst = 0;

    @(negedge clk);
    a_num = 16'd42; a_iv = 1;
    @(negedge clk);
    a_iv = 0;
    g = 0;
    while (!a_ov && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("rst_emit_reached", a_ov, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_emit_out_valid", a_ov, 0);
    chk("rst_emit_in_ready", a_ir, 1);
    @(negedge clk);
    rst = 0;
    xfer(0, 32'd7, 0, 0, 17, 1);

    xfer(1, 32'd4294967295, 0, 0, 33, 0);
    xfer(1, 32'hDEAD0001, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
